// File: rtl/serial_pkg.sv
// Shared frame constants and state encodings for the serial UART.
// No ports; imported by the UART top and its interface users.
package serial_pkg;

   localparam int DATA_BITS = 8;
   localparam int BIT_IDX_W = $clog2(DATA_BITS);
   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/serial_if.sv
// Bundle of the UART line and host-side signals.
//   rx        serial receive line (idle high, asynchronous)
//   tx        serial transmit line (idle high)
//   dat_t     byte to transmit, captured when txe is accepted
//   txe       transmit request
//   tx_busy   frame in progress on tx
//   dat_r     last correctly received byte
//   ready     sticky "byte available" flag
//   ready_rst synchronous clear of ready
// slave: the UART side; master: the host / line driver side.
interface serial_if;
   import serial_pkg::*;

   logic                 rx;
   logic                 tx;
   logic [DATA_BITS-1:0] dat_t;
   logic                 txe;
   logic                 tx_busy;
   logic [DATA_BITS-1:0] dat_r;
   logic                 ready;
   logic                 ready_rst;

   modport slave (
      input  rx, dat_t, txe, ready_rst,
      output tx, tx_busy, dat_r, ready
   );

   modport master (
      output rx, dat_t, txe, ready_rst,
      input  tx, tx_busy, dat_r, ready
   );

endinterface

// File: rtl/serial_baud_cnt.sv
// Bit-period counter. Counts 0..CLK_MUL-1 while enabled and pulses tick
// on the last count. clear holds it at 0. With HALF_FIRST set, the first
// period after a clear is only CLK_MUL/2 long, which lets the receiver land
// on the middle of the start bit and then stay mid-bit for every later tick.
//   clk, rst    clock, asynchronous active-low reset
//   clear       restart the count (and re-arm the short first period)
//   enable      advance the count
//   tick        one-cycle pulse at the end of each period
module serial_baud_cnt #(
   parameter int CLK_MUL       = 5208,
   parameter int CLK_MUL_WIDTH = $clog2(CLK_MUL + 1),
   parameter bit HALF_FIRST    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [CLK_MUL_WIDTH-1:0] LAST = CLK_MUL_WIDTH'(CLK_MUL - 1);
   localparam logic [CLK_MUL_WIDTH-1:0] HALF = CLK_MUL_WIDTH'(CLK_MUL / 2 - 1);

   logic [CLK_MUL_WIDTH-1:0] cnt_q, cnt_d;
   logic                     first_q, first_d;
   logic [CLK_MUL_WIDTH-1:0] limit;

   always_comb begin
      limit   = (HALF_FIRST && first_q) ? HALF : LAST;
      cnt_d   = cnt_q;
      first_d = first_q;
      if (clear) begin
         cnt_d   = '0;
         first_d = 1'b1;
      end else if (enable) begin
         if (cnt_q == limit) begin
            cnt_d   = '0;
            first_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign tick = enable && !clear && (cnt_q == limit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         first_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/serial.sv
// 8N1 UART with independent transmitter and receiver.
//   clk      system clock (rising edge)
//   rst      asynchronous active-low reset
//   bus      serial_if.slave: rx/tx line, dat_t/txe/tx_busy transmit side,
//            dat_r/ready/ready_rst receive side
// CLK_MUL = CLK_FREQ/BAUD clocks per bit.
module serial
   import serial_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input logic     clk,
   input logic     rst,
   serial_if.slave bus
);

   localparam int CLK_MUL       = CLK_FREQ / BAUD;
   localparam int CLK_MUL_WIDTH = $clog2(CLK_MUL + 1);

   tx_state_e                tx_state_q, tx_state_d;
   logic [DATA_BITS-1:0]     tx_shift_q, tx_shift_d;
   logic [BIT_IDX_W-1:0]     tx_idx_q, tx_idx_d;
   logic                     tx_q, tx_d;
   logic                     tx_busy_q, tx_busy_d;
   logic                     tx_tick;

   rx_state_e                rx_state_q, rx_state_d;
   logic [DATA_BITS-1:0]     rx_shift_q, rx_shift_d;
   logic [BIT_IDX_W-1:0]     rx_idx_q, rx_idx_d;
   logic                     rx_s1_q, rx_s2_q;
   logic [DATA_BITS-1:0]     dat_r_q, dat_r_d;
   logic                     ready_q, ready_d;
   logic                     rx_tick;
   logic                     rx_set;

   serial_baud_cnt #(
      .CLK_MUL       (CLK_MUL),
      .CLK_MUL_WIDTH (CLK_MUL_WIDTH),
      .HALF_FIRST    (1'b0)
   ) u_tx_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (tx_state_q == TX_IDLE),
      .enable (tx_state_q != TX_IDLE),
      .tick   (tx_tick)
   );

   // The receive counter's first period is half a bit, so its ticks fall
   // mid-start, then mid-bit for every data bit and the stop bit.
   serial_baud_cnt #(
      .CLK_MUL       (CLK_MUL),
      .CLK_MUL_WIDTH (CLK_MUL_WIDTH),
      .HALF_FIRST    (1'b1)
   ) u_rx_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (rx_state_q == RX_IDLE),
      .enable (rx_state_q != RX_IDLE),
      .tick   (rx_tick)
   );

   // Transmitter: tx is registered, so each line level changes on the same
   // edge as the state that owns it.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_idx_d   = tx_idx_q;
      tx_d       = tx_q;
      tx_busy_d  = tx_busy_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            tx_d      = 1'b1;
            tx_busy_d = 1'b0;
            if (bus.txe) begin
               tx_shift_d = bus.dat_t;
               tx_state_d = TX_START;
               tx_d       = 1'b0;
               tx_busy_d  = 1'b1;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_idx_d   = '0;
               tx_d       = tx_shift_q[0];
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               if (tx_idx_q == LAST_BIT) begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_d       = tx_shift_q[1];
               end
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               tx_state_d = TX_IDLE;
               tx_d       = 1'b1;
               tx_busy_d  = 1'b0;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Receiver: rx_s2_q is the only view of the line the FSM ever uses.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_idx_d   = rx_idx_q;
      dat_r_d    = dat_r_q;
      rx_set     = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_tick) begin
               // Line back high at mid-start means a glitch, not a frame.
               rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               rx_idx_d   = '0;
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
               rx_idx_d   = rx_idx_q + 1'b1;
               if (rx_idx_q == LAST_BIT) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               rx_state_d = RX_IDLE;
               if (rx_s2_q) begin
                  dat_r_d = rx_shift_q;
                  rx_set  = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      // A new byte outranks a simultaneous clear request.
      ready_d = rx_set ? 1'b1 : (bus.ready_rst ? 1'b0 : ready_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_shift_q <= '0;
         tx_idx_q   <= '0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         rx_state_q <= RX_IDLE;
         rx_shift_q <= '0;
         rx_idx_q   <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         dat_r_q    <= '0;
         ready_q    <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_idx_q   <= tx_idx_d;
         tx_q       <= tx_d;
         tx_busy_q  <= tx_busy_d;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_idx_q   <= rx_idx_d;
         rx_s1_q    <= bus.rx;
         rx_s2_q    <= rx_s1_q;
         dat_r_q    <= dat_r_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = tx_busy_q;
   assign bus.dat_r   = dat_r_q;
   assign bus.ready   = ready_q;

endmodule

// File: tb/tb_serial.sv
// Directed testbench for the serial UART. The main instance runs at
// 10 clocks per bit to keep frames short; a second instance with default
// parameters is used only to measure the real 50 MHz / 9600 bit period.
module tb_serial;

   localparam int M = 10;      // 1_000_000 / 100_000
   localparam int H = M / 2;

   logic clk;
   logic rst;
   logic rst_d;
   int   n_tests;
   int   n_fail;
   int   lat;
   int   lat2;
   int   n;

   serial_if bus ();
   serial_if bus_d ();

   serial #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   serial dut_def (
      .clk (clk),
      .rst (rst_d),
      .bus (bus_d.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sends one byte and checks every bit's level and duration, that a
   // request during the frame is ignored and that the line goes idle after.
   task automatic tx_frame(input logic [7:0] d, input string tag);
      logic [9:0] bits;
      int         match[10];
      int         busy_n;
      bits = {1'b1, d, 1'b0};
      check($sformatf("%s_idle", tag), {bus.tx, bus.tx_busy}, 2'b10);
      bus.dat_t = d;
      bus.txe   = 1'b1;
      @(negedge clk);
      bus.txe   = 1'b0;
      bus.dat_t = ~d;
      busy_n    = 0;
      for (int k = 0; k < 10; k++) match[k] = 0;
      for (int c = 0; c < 10 * M; c++) begin
         bus.txe = (c == 3 * M / 2);
         if (bus.tx == bits[c / M]) match[c / M]++;
         if (bus.tx_busy) busy_n++;
         @(negedge clk);
      end
      bus.txe = 1'b0;
      for (int k = 0; k < 10; k++)
         check($sformatf("%s_bit%0d", tag, k), match[k], M);
      check($sformatf("%s_busy_cycles", tag), busy_n, 10 * M);
      check($sformatf("%s_end", tag), {bus.tx, bus.tx_busy}, 2'b10);
   endtask

   // Drives one frame on rx, one bit per M clocks. lat is the number of
   // clocks from the start edge to the first clock ready is seen rising.
   // ready_rst is pulsed for the cycle whose index equals clr_at.
   task automatic rx_frame(input logic [7:0] d, input logic stop, input int clr_at,
                           output int lat_o);
      logic [9:0] bits;
      logic       prev;
      bits  = {stop, d, 1'b0};
      lat_o = -1;
      prev  = bus.ready;
      for (int k = 0; k < 10; k++) begin
         bus.rx = bits[k];
         for (int c = 0; c < M; c++) begin
            bus.ready_rst = ((k * M + c) == clr_at);
            @(negedge clk);
            if (bus.ready && !prev && lat_o < 0) lat_o = k * M + c + 1;
            prev = bus.ready;
         end
      end
      bus.rx        = 1'b1;
      bus.ready_rst = 1'b0;
   endtask

   task automatic clear_ready();
      bus.ready_rst = 1'b1;
      @(negedge clk);
      bus.ready_rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      rst_d   = 1'b0;
      bus.rx = 1'b1; bus.txe = 1'b0; bus.dat_t = 8'h00; bus.ready_rst = 1'b0;
      bus_d.rx = 1'b1; bus_d.txe = 1'b0; bus_d.dat_t = 8'h00; bus_d.ready_rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", bus.tx, 1'b1);
      check("rst_busy", bus.tx_busy, 1'b0);
      check("rst_dat_r", bus.dat_r, 8'h00);
      check("rst_ready", bus.ready, 1'b0);
      rst   = 1'b1;
      rst_d = 1'b1;
      @(negedge clk);

      // Default parameters: start bit must last 50e6/9600 = 5208 clocks.
      bus_d.dat_t = 8'hFF;
      bus_d.txe   = 1'b1;
      @(negedge clk);
      bus_d.txe = 1'b0;
      n = 0;
      while (bus_d.tx == 1'b0 && n < 6000) begin
         n++;
         @(negedge clk);
      end
      check("default_bit_period", n, 5208);
      rst_d = 1'b0;
      #1;
      check("default_abort_tx", {bus_d.tx, bus_d.tx_busy}, 2'b10);

      // Transmit, then a back-to-back frame the clock after STOP ends.
      @(negedge clk);
      tx_frame(8'h59, "tx59");
      tx_frame(8'hC3, "tx_b2b");

      // Receive: 2 sync clocks + 1 detect clock + half bit + 9 bits.
      rx_frame(8'h34, 1'b1, -1, lat);
      check("rx34_latency", lat, 3 + H + 9 * M);
      check("rx34_ready", bus.ready, 1'b1);
      check("rx34_dat_r", bus.dat_r, 8'h34);
      repeat (M) @(negedge clk);

      clear_ready();
      check("clr_ready", bus.ready, 1'b0);
      check("clr_dat_r", bus.dat_r, 8'h34);

      // ready_rst high on the very edge that sets ready: set wins.
      rx_frame(8'h5A, 1'b1, 3 + H + 9 * M - 1, lat);
      check("set_wins_latency", lat, 3 + H + 9 * M);
      check("set_wins_ready", bus.ready, 1'b1);
      check("set_wins_dat_r", bus.dat_r, 8'h5A);

      // New byte while ready is still set overwrites and keeps ready.
      rx_frame(8'hE7, 1'b1, -1, lat);
      check("overwrite_ready", bus.ready, 1'b1);
      check("overwrite_dat_r", bus.dat_r, 8'hE7);

      // Short low glitch must not start a reception.
      clear_ready();
      bus.rx = 1'b0;
      repeat (2) @(negedge clk);
      bus.rx = 1'b1;
      repeat (12 * M) @(negedge clk);
      check("glitch_ready", bus.ready, 1'b0);
      check("glitch_dat_r", bus.dat_r, 8'hE7);

      // Framing error: stop bit 0 discards the byte.
      rx_frame(8'h81, 1'b0, -1, lat);
      repeat (2 * M) @(negedge clk);
      check("frame_err_ready", bus.ready, 1'b0);
      check("frame_err_dat_r", bus.dat_r, 8'hE7);

      rx_frame(8'h3C, 1'b1, -1, lat);
      check("recover_ready", bus.ready, 1'b1);
      check("recover_dat_r", bus.dat_r, 8'h3C);
      repeat (M) @(negedge clk);

      // Transmit and receive at the same time.
      fork
         tx_frame(8'h96, "tx_sim");
         rx_frame(8'h69, 1'b1, -1, lat2);
      join
      check("sim_rx_dat_r", bus.dat_r, 8'h69);
      check("sim_rx_ready", bus.ready, 1'b1);

      // Reset in the middle of a frame, then a clean frame afterwards.
      bus.dat_t = 8'hA5;
      bus.txe   = 1'b1;
      @(negedge clk);
      bus.txe = 1'b0;
      repeat (3 * M) @(negedge clk);
      check("pre_rst_busy", bus.tx_busy, 1'b1);
      rst = 1'b0;
      #1;
      check("midrst_tx", {bus.tx, bus.tx_busy}, 2'b10);
      check("midrst_rx", {bus.ready, bus.dat_r}, 9'h000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tx_frame(8'hA5, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial.md
SERIAL -- requirements
Module: serial

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s.
REQ-003 Parameter CLK_MUL, default CLK_FREQ/BAUD (integer division, 5208), clocks per bit period; derived, not overridden.
REQ-004 Parameter CLK_MUL_WIDTH, default $clog2(CLK_MUL+1) (13), counter width; derived.
REQ-005 clk  input  1  single system clock, rising-edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 rx  input  1  serial receive line, idle high, asynchronous to clk.
REQ-008 tx  output  1  serial transmit line, idle high.
REQ-009 dat_t  input  8  byte to transmit, sampled when txe is accepted.
REQ-010 txe  input  1  transmit request, level-sampled each clk; a 1-cycle pulse suffices.
REQ-011 tx_busy  output  1  high while a frame is being transmitted.
REQ-012 dat_r  output  8  last correctly received byte.
REQ-013 ready  output  1  sticky flag, high once a valid byte is in dat_r.
REQ-014 ready_rst  input  1  synchronous clear of ready.

Function
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly CLK_MUL clocks.
REQ-016 TX states SHALL be IDLE, START, DATA, STOP; IDLE holds tx=1, tx_busy=0.
REQ-017 In IDLE, txe=1 SHALL latch dat_t and enter START on the next clk; tx falls to 0 that same edge.
REQ-018 START lasts CLK_MUL clocks, DATA 8xCLK_MUL clocks (bit index 0..7), STOP CLK_MUL clocks with tx=1, then IDLE.
REQ-019 txe while tx_busy=1 SHALL be ignored; back-to-back frames are allowed from IDLE the clock after STOP ends.
REQ-020 rx SHALL pass through a 2-flop synchronizer before any use; RX latency includes these 2 clocks.
REQ-021 RX states SHALL be IDLE, START, DATA, STOP; IDLE waits for synchronized rx=0.
REQ-022 In START, rx SHALL be resampled after CLK_MUL/2 clocks; if rx=1 (glitch), return to IDLE with no effect.
REQ-023 Data bits SHALL be sampled every CLK_MUL clocks after the mid-start point, shifted LSB first.
REQ-024 Stop bit SHALL be sampled CLK_MUL clocks after bit 7; if 1, dat_r takes the shifted byte and ready sets on the same edge; if 0 (framing error), the byte is discarded, dat_r and ready are unchanged.
REQ-025 After the stop sample, RX SHALL return to IDLE immediately and accept a new start edge.
REQ-026 ready_rst=1 SHALL clear ready on the next edge; if it coincides with a ready-set event, the set wins.
REQ-027 A new valid byte while ready=1 SHALL overwrite dat_r and keep ready=1; no overrun flag.
REQ-028 TX and RX SHALL be fully independent and may operate simultaneously.
REQ-029 Bit counters SHALL count 0..CLK_MUL-1 in CLK_MUL_WIDTH bits and never wrap mid-bit.

Reset
REQ-030 rst=0 SHALL asynchronously force: TX and RX to IDLE, tx=1, tx_busy=0, dat_r=8'h00, ready=0, synchronizer flops=1, all counters 0.
REQ-031 Reset mid-frame SHALL abort the frame; tx returns to 1 immediately; no partial byte is delivered.
REQ-032 Release of rst SHALL take effect on the next clk edge; no operation in the same cycle.

Structure
REQ-033 Frame constants (data bit count 8, state encodings for TX and RX) SHALL live in a shared package serial_pkg; CLK_FREQ/BAUD stay module parameters.
REQ-034 One sub-module serial_baud_cnt (parameter CLK_MUL, inputs clear/enable, output tick) SHALL be instantiated once for TX and once for RX; all else is inline.

Verification
REQ-035 Parameter check: defaults -> CLK_MUL=5208, CLK_MUL_WIDTH=13 at a 50 MHz clk (20 ns period).
REQ-036 TX: dat_t=8'h59, 1-cycle txe pulse 10 us after reset -> tx sequence 0,1,0,0,1,1,0,1,0,1, each 5208 clocks, tx_busy high for 52080 clocks, then tx=1.
REQ-037 RX: start bit then 8'h34 LSB first at 104166 ns per bit, then rx=1 -> ready=1 and dat_r=8'h34 about 9.5 bit times after the start edge.
REQ-038 Clear: ready_rst 1-cycle pulse after ready=1 -> ready=0, dat_r stays 8'h34; a pulse coinciding with the set edge -> ready=1.
REQ-039 Errors: rx low pulse of 1 us -> no reception; frame with stop bit 0 -> ready and dat_r unchanged.
REQ-040 Reset: rst=0 mid-TX of 8'hA5 -> tx=1, tx_busy=0 immediately; a subsequent txe sends a full clean frame.
